// File: rtl/tone_source.sv
// Note-playback tone generator with an independent tremolo square wave.
// Optional post-note silence (GAP state) is compiled in with `define TONE_GAP_EN.
module tone_source #(
  parameter int PERIOD_W  = 16,
  parameter int DUR_W     = 8,
  parameter int TICK_DIV  = 1000,
  parameter int TREM_HALF = 5000,
  parameter int GAP_TICKS = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PERIOD_W-1:0] note_period,
  input  logic [DUR_W-1:0]    note_dur,
  input  logic                note_valid,
  output logic                note_ready,
  input  logic                stop,
  input  logic                trem_en,
  output logic                tone,
  output logic                trem,
  output logic                busy,
  output logic                done
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TREM_W = (TREM_HALF > 1) ? $clog2(TREM_HALF) : 1;
  localparam int GAP_W  = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam int CNT_W  = (DUR_W > GAP_W) ? DUR_W : GAP_W;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [TREM_W-1:0] TREM_LAST = TREM_W'(TREM_HALF - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
`ifdef TONE_GAP_EN
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam bit         GAP_ON = (GAP_TICKS != 0);
  localparam logic [CNT_W-1:0] GAP_END = CNT_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
`endif

  logic [1:0]          state;
  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] phase_cnt;
  logic [DUR_W-1:0]    note_len;
  logic [TICK_W-1:0]   tick_cnt;
  logic [CNT_W-1:0]    dur_cnt;
  logic [CNT_W-1:0]    dur_end;
  logic [TREM_W-1:0]   trem_cnt;
  logic                tick_last;
  logic                phase_hit;
  logic                end_hit;

  // dur_cnt counts completed ticks; the end edge is the last cycle of the last tick,
  // so no counter ever has to hold D*TICK_DIV itself.
  always_comb begin
    tick_last = (tick_cnt == TICK_LAST);
    phase_hit = (period != '0) && (phase_cnt == period - 1'b1);
    dur_end   = CNT_W'(note_len) - CNT_W'(1);
`ifdef TONE_GAP_EN
    if (state == S_GAP) dur_end = GAP_END;
`endif
    end_hit   = tick_last && (dur_cnt == dur_end);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      period     <= '0;
      note_len   <= '0;
      phase_cnt  <= '0;
      tick_cnt   <= '0;
      dur_cnt    <= '0;
      tone       <= 1'b0;
      note_ready <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (note_valid && note_ready) begin
            period     <= note_period;
            note_len   <= (note_dur == '0) ? DUR_W'(1) : note_dur;
            phase_cnt  <= '0;
            tick_cnt   <= '0;
            dur_cnt    <= '0;
            tone       <= 1'b0;
            busy       <= 1'b1;
            note_ready <= 1'b0;
            state      <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (stop) begin
            state      <= S_IDLE;
            phase_cnt  <= '0;
            tick_cnt   <= '0;
            dur_cnt    <= '0;
            tone       <= 1'b0;
            busy       <= 1'b0;
            note_ready <= 1'b1;
          end else if (end_hit) begin
            phase_cnt <= '0;
            tick_cnt  <= '0;
            dur_cnt   <= '0;
            tone      <= 1'b0;
`ifdef TONE_GAP_EN
            if (GAP_ON) begin
              state <= S_GAP;
            end else begin
              state      <= S_IDLE;
              busy       <= 1'b0;
              note_ready <= 1'b1;
              done       <= 1'b1;
            end
`else
            state      <= S_IDLE;
            busy       <= 1'b0;
            note_ready <= 1'b1;
            done       <= 1'b1;
`endif
          end else begin
            if (tick_last) begin
              tick_cnt <= '0;
              dur_cnt  <= dur_cnt + CNT_W'(1);
            end else begin
              tick_cnt <= tick_cnt + TICK_W'(1);
            end
            // A rest (period 0) never toggles, so its phase counter stays parked.
            if (phase_hit) begin
              phase_cnt <= '0;
              tone      <= ~tone;
            end else if (period != '0) begin
              phase_cnt <= phase_cnt + PERIOD_W'(1);
            end
          end
        end
`ifdef TONE_GAP_EN
        S_GAP: begin
          if (stop || end_hit) begin
            state      <= S_IDLE;
            tick_cnt   <= '0;
            dur_cnt    <= '0;
            busy       <= 1'b0;
            note_ready <= 1'b1;
            done       <= end_hit && !stop;
          end else if (tick_last) begin
            tick_cnt <= '0;
            dur_cnt  <= dur_cnt + CNT_W'(1);
          end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
          end
        end
`endif
        default: begin
          state      <= S_IDLE;
          phase_cnt  <= '0;
          tick_cnt   <= '0;
          dur_cnt    <= '0;
          tone       <= 1'b0;
          busy       <= 1'b0;
          note_ready <= 1'b1;
        end
      endcase
    end
  end

  // Tremolo runs regardless of note state; disabling it parks the wave low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trem_cnt <= '0;
      trem     <= 1'b0;
    end else if (!trem_en) begin
      trem_cnt <= '0;
      trem     <= 1'b0;
    end else if (trem_cnt == TREM_LAST) begin
      trem_cnt <= '0;
      trem     <= ~trem;
    end else begin
      trem_cnt <= trem_cnt + TREM_W'(1);
    end
  end

endmodule

// File: tb/tb_tone_source.sv
// Self-checking bench for tone_source: directed scenarios plus randomized traffic
// against a cycle-count reference model.
module tb_tone_source;
  localparam int PW = 16;
  localparam int DW = 8;
  localparam int TD = 4;
  localparam int TH = 3;
  localparam int GT = 2;
`ifdef TONE_GAP_EN
  localparam int GC = GT * TD;
`else
  localparam int GC = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] note_period;
  logic [DW-1:0] note_dur;
  logic          note_valid, stop, trem_en;
  wire           note_ready, tone, trem, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  tone_source #(.PERIOD_W(PW), .DUR_W(DW), .TICK_DIV(TD), .TREM_HALF(TH), .GAP_TICKS(GT)) dut (
    .clk(clk), .rst(rst), .note_period(note_period), .note_dur(note_dur),
    .note_valid(note_valid), .note_ready(note_ready), .stop(stop), .trem_en(trem_en),
    .tone(tone), .trem(trem), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: m_c counts edges since accept; tone is bit 0 of c/P.
  int   m_state = 0, m_c = 0, m_p = 0, m_d = 1, m_n = 0;
  logic m_tone = 1'b0, m_trem = 1'b0, m_done = 1'b0;
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_state = 0; m_c = 0; m_tone = 0; m_done = 0; m_n = 0; m_trem = 0;
    end else begin
      m_done = 0;
      if (m_state == 0) begin
        if (note_valid) begin
          m_p = int'(note_period);
          m_d = (note_dur == 0) ? 1 : int'(note_dur);
          m_c = 0; m_state = 1; m_tone = 0;
        end
      end else if (m_state == 1) begin
        if (stop) begin
          m_state = 0; m_tone = 0;
        end else begin
          m_c++;
          if (m_c == m_d * TD) begin
            m_tone = 0;
            if (GC > 0) begin m_state = 2; m_c = 0; end
            else begin m_state = 0; m_done = 1; end
          end else begin
            m_tone = (m_p != 0) && (((m_c / m_p) % 2) == 1);
          end
        end
      end else begin
        if (stop) m_state = 0;
        else begin
          m_c++;
          if (m_c == GC) begin m_state = 0; m_done = 1; end
        end
      end
      if (!trem_en) m_n = 0; else m_n++;
      m_trem = ((m_n / TH) % 2) == 1;
    end
  end

  wire [4:0] m_vec   = {m_tone, m_trem, m_state != 0, m_state == 0, m_done};
  wire [4:0] dut_vec = {tone, trem, busy, note_ready, done};

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic accept(input int p, input int d);
    note_period = PW'(p); note_dur = DW'(d); note_valid = 1'b1;
    tick();
    note_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_tests++;
    if (dut_vec !== 5'b00010) begin
      n_fail++; $display("FAIL reset_state got=%b exp=%b", dut_vec, 5'b00010);
    end
    rst = 1'b0;
    accept(2, 5);
    for (int c = 1; c <= 7; c++) begin
      tick(); n_tests++;
      if (dut_vec !== m_vec) begin
        n_fail++; $display("FAIL pre_reset c=%0d got=%b exp=%b", c, dut_vec, m_vec);
      end
    end
    #2 rst = 1'b1;
    #1 n_tests++;
    if (dut_vec !== 5'b00010) begin
      n_fail++; $display("FAIL reset_mid_note got=%b exp=%b", dut_vec, 5'b00010);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick(); n_tests++;
      if (done !== 1'b0 || dut_vec !== m_vec) begin
        n_fail++; $display("FAIL post_reset c=%0d got=%b exp=%b", c, dut_vec, m_vec);
      end
    end
  endtask

  task automatic test_tone_basic();
    accept(3, 2);
    for (int c = 1; c <= 14 + 2 * GC; c++) begin
      tick(); n_tests++;
      if (dut_vec !== m_vec) begin
        n_fail++; $display("FAIL tone_basic c=%0d got=%b exp=%b", c, dut_vec, m_vec);
      end
      if (c == 3 || c == 6) begin
        n_tests++;
        if (tone !== (c == 3)) begin
          n_fail++; $display("FAIL tone_edge c=%0d got=%b exp=%b", c, tone, c == 3);
        end
      end
      if (c == 8 + GC) begin
        n_tests++;
        if ({done, note_ready, tone} !== 3'b110) begin
          n_fail++; $display("FAIL note_end c=%0d got=%b exp=110", c, {done, note_ready, tone});
        end
        note_period = 2; note_dur = 1; note_valid = 1'b1;
      end
      if (c == 9 + GC) begin
        n_tests++;
        if ({busy, done} !== 2'b10) begin
          n_fail++; $display("FAIL back_to_back c=%0d got=%b exp=10", c, {busy, done});
        end
        note_valid = 1'b0;
      end
    end
  endtask

  task automatic test_rest();
    accept(0, 0);
    for (int c = 1; c <= 6 + GC; c++) begin
      tick(); n_tests++;
      if (dut_vec !== m_vec || tone !== 1'b0) begin
        n_fail++; $display("FAIL rest c=%0d got=%b exp=%b", c, dut_vec, m_vec);
      end
      if (c == 4 + GC) begin
        n_tests++;
        if (done !== 1'b1) begin
          n_fail++; $display("FAIL rest_done c=%0d got=%b exp=1", c, done);
        end
      end
    end
  endtask

  task automatic test_stop();
    accept(1, 3);
    for (int c = 1; c <= 9; c++) begin
      tick(); n_tests++;
      if (dut_vec !== m_vec) begin
        n_fail++; $display("FAIL stop_mid c=%0d got=%b exp=%b", c, dut_vec, m_vec);
      end
      if (c <= 5) begin
        n_tests++;
        if (tone !== c[0]) begin
          n_fail++; $display("FAIL p1_toggle c=%0d got=%b exp=%b", c, tone, c[0]);
        end
      end
      if (c == 5) stop = 1'b1;
      if (c == 6) begin
        stop = 1'b0; n_tests++;
        if ({busy, note_ready, tone, done} !== 4'b0100) begin
          n_fail++; $display("FAIL stop_idle c=%0d got=%b exp=0100", c, {busy, note_ready, tone, done});
        end
      end
    end
    accept(1, 3);
    for (int c = 1; c <= 15; c++) begin
      tick(); n_tests++;
      if (dut_vec !== m_vec || done !== 1'b0) begin
        n_fail++; $display("FAIL stop_at_end c=%0d got=%b exp=%b", c, dut_vec, m_vec);
      end
      if (c == 11) stop = 1'b1;
      if (c == 12) stop = 1'b0;
    end
    // stop while idle must not block an accept
    stop = 1'b1;
    accept(2, 1);
    stop = 1'b0;
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL stop_in_idle got=%b exp=1", busy);
    end
    for (int c = 1; c <= 6 + GC; c++) begin
      tick(); n_tests++;
      if (dut_vec !== m_vec) begin
        n_fail++; $display("FAIL stop_in_idle_run c=%0d got=%b exp=%b", c, dut_vec, m_vec);
      end
    end
  endtask

  task automatic test_trem();
    logic exp_t;
    trem_en = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      tick();
      exp_t = (k >= 3 && k <= 5) || (k >= 9 && k <= 10) || (k >= 16);
      n_tests++;
      if (trem !== exp_t || dut_vec !== m_vec) begin
        n_fail++; $display("FAIL trem k=%0d got=%b exp=%b", k, trem, exp_t);
      end
      if (k == 10) trem_en = 1'b0;
      if (k == 13) trem_en = 1'b1;
    end
    trem_en = 1'b0;
    tick();
  endtask

  task automatic test_max_fields();
    accept((1 << PW) - 1, (1 << DW) - 1);
    for (int c = 1; c <= 1021 + GC; c++) begin
      tick(); n_tests++;
      if (dut_vec !== m_vec) begin
        n_fail++; $display("FAIL max_fields c=%0d got=%b exp=%b", c, dut_vec, m_vec);
      end
      if (c == 1020 + GC) begin
        n_tests++;
        if (done !== 1'b1) begin
          n_fail++; $display("FAIL max_done c=%0d got=%b exp=1", c, done);
        end
      end
    end
  endtask

`ifdef TONE_GAP_EN
  task automatic test_gap();
    accept(2, 1);
    note_valid = 1'b1; note_period = 3; note_dur = 1;
    for (int c = 1; c <= 30; c++) begin
      tick(); n_tests++;
      if (dut_vec !== m_vec) begin
        n_fail++; $display("FAIL gap c=%0d got=%b exp=%b", c, dut_vec, m_vec);
      end
      if (c == 4) begin
        n_tests++;
        if ({tone, busy, note_ready, done} !== 4'b0100) begin
          n_fail++; $display("FAIL gap_enter got=%b exp=0100", {tone, busy, note_ready, done});
        end
      end
      if (c > 4 && c < 12) begin
        n_tests++;
        if ({busy, note_ready} !== 2'b10) begin
          n_fail++; $display("FAIL gap_hold c=%0d got=%b exp=10", c, {busy, note_ready});
        end
      end
      if (c == 12) begin
        n_tests++;
        if ({done, note_ready} !== 2'b11) begin
          n_fail++; $display("FAIL gap_done got=%b exp=11", {done, note_ready});
        end
      end
      if (c == 13) note_valid = 1'b0;
    end
  endtask
`endif

  task automatic test_random();
    int r;
    for (int c = 0; c < 3000; c++) begin
      note_valid = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 9);
      note_period = (r == 0) ? PW'(0) : (r == 1) ? PW'(1) : PW'($urandom_range(2, 6));
      note_dur = DW'($urandom_range(0, 3));
      stop = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 39) == 0) trem_en = ~trem_en;
      tick(); n_tests++;
      if (dut_vec !== m_vec) begin
        n_fail++; $display("FAIL random c=%0d got=%b exp=%b", c, dut_vec, m_vec);
      end
    end
    note_valid = 1'b0; stop = 1'b0; trem_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; note_period = '0; note_dur = '0; note_valid = 1'b0; stop = 1'b0; trem_en = 1'b0;
    test_reset();
    test_tone_basic();
    test_rest();
    test_stop();
    test_trem();
    test_max_fields();
`ifdef TONE_GAP_EN
    test_gap();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end
endmodule
